pipeline_consumer_checker: RTL

Sink-side counterpart of the dual-lane producer: terminates the two pipeline output streams (data, valid, flush), checks that each lane delivers its stride-2 counter sequence in order, and drives the `global_stall` that freezes producer and pipelines. It sits at the tail of the global-stall test harness and provides pass/fail status and traffic counters for the top-level bench.

---
 rtl/pipeline_consumer_checker.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_consumer_checker.sv
// Sink-side checker for the dual-lane global-stall harness: verifies each lane's
// stride-2 sequence, counts traffic and errors, and drives the registered global stall.

// Beat semantics: a lane beat is taken only in a cycle where the registered
// global_stall is low. valid marks a checkable data word and flush marks a slot
// that consumes a sequence value. Both high is a protocol error handled as a flush.
// While global_stall is high, upstream holds its outputs frozen, so beats are ignored.

module pipeline_consumer_lane #(
    parameter bit PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [31:0] data_i,
    output logic        locked_o,
    output logic        err_o,
    output logic [31:0] rx_count_o,
    output logic [15:0] flush_count_o,
    output logic [15:0] err_count_o,
    output logic        state_o
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lane_state_t;

    lane_state_t state_q, state_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] rx_q, rx_d;
    logic [15:0] fl_q, fl_d;
    logic [15:0] ecnt_q, ecnt_d;
    logic        err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            exp_q   <= '0;
            rx_q    <= '0;
            fl_q    <= '0;
            ecnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            rx_q    <= rx_d;
            fl_q    <= fl_d;
            ecnt_q  <= ecnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        rx_d    = rx_q;
        fl_d    = fl_q;
        ecnt_d  = ecnt_q;
        err_d   = 1'b0;

        if (accept_i) begin
            if (flush_i) begin
                // A flushed slot still consumes one sequence value once locked.
                fl_d  = fl_q + 16'd1;
                err_d = valid_i;
                if (state_q == LOCKED) begin
                    exp_d = exp_q + 32'd2;
                end
            end else if (valid_i) begin
                rx_d = rx_q + 32'd1;
                if (state_q == UNLOCKED) begin
                    if (data_i[0] == PARITY) begin
                        exp_d   = data_i + 32'd2;
                        state_d = LOCKED;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (data_i == exp_q) begin
                    exp_d = exp_q + 32'd2;
                end else begin
                    // Resync on the observed value so one glitch gives one error.
                    err_d = 1'b1;
                    exp_d = data_i + 32'd2;
                end
            end
        end

        if (err_d && (ecnt_q != 16'hFFFF)) begin
            ecnt_d = ecnt_q + 16'd1;
        end
    end

    assign locked_o      = (state_q == LOCKED);
    assign err_o         = err_q;
    assign rx_count_o    = rx_q;
    assign flush_count_o = fl_q;
    assign err_count_o   = ecnt_q;
    assign state_o       = state_q;

endmodule

module pipeline_consumer_checker #(
    parameter int STALL_PERIOD = 0,
    parameter bit LANE1_PARITY = 1'b0,
    parameter bit LANE2_PARITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data_1,
    input  logic [31:0] in_data_2,
    input  logic        in_valid_1,
    input  logic        in_valid_2,
    input  logic        in_flush_1,
    input  logic        in_flush_2,
    input  logic        sink_ready,
    output logic        global_stall,
    output logic        locked_1,
    output logic        locked_2,
    output logic        err_1,
    output logic        err_2,
    output logic [31:0] rx_count_1,
    output logic [31:0] rx_count_2,
    output logic [15:0] flush_count_1,
    output logic [15:0] flush_count_2,
    output logic [15:0] err_count_1,
    output logic [15:0] err_count_2,
    output logic        dbg_state_1,
    output logic        dbg_state_2
);

    logic        stall_q, stall_d;
    logic [31:0] inj_cnt_q, inj_cnt_d;
    logic        inject;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q   <= 1'b0;
            inj_cnt_q <= '0;
        end else begin
            stall_q   <= stall_d;
            inj_cnt_q <= inj_cnt_d;
        end
    end

    // Free-running injection counter; stays at zero when injection is disabled.
    always_comb begin
        inject    = 1'b0;
        inj_cnt_d = inj_cnt_q;
        if (STALL_PERIOD > 0) begin
            if (inj_cnt_q == 32'(STALL_PERIOD - 1)) begin
                inject    = 1'b1;
                inj_cnt_d = '0;
            end else begin
                inj_cnt_d = inj_cnt_q + 32'd1;
            end
        end
        stall_d = ~sink_ready | inject;
    end

    assign accept       = ~stall_q;
    assign global_stall = stall_q;

    pipeline_consumer_lane #(.PARITY(LANE1_PARITY)) u_lane_1 (
        .clk           (clk),
        .reset         (reset),
        .accept_i      (accept),
        .valid_i       (in_valid_1),
        .flush_i       (in_flush_1),
        .data_i        (in_data_1),
        .locked_o      (locked_1),
        .err_o         (err_1),
        .rx_count_o    (rx_count_1),
        .flush_count_o (flush_count_1),
        .err_count_o   (err_count_1),
        .state_o       (dbg_state_1)
    );

    pipeline_consumer_lane #(.PARITY(LANE2_PARITY)) u_lane_2 (
        .clk           (clk),
        .reset         (reset),
        .accept_i      (accept),
        .valid_i       (in_valid_2),
        .flush_i       (in_flush_2),
        .data_i        (in_data_2),
        .locked_o      (locked_2),
        .err_o         (err_2),
        .rx_count_o    (rx_count_2),
        .flush_count_o (flush_count_2),
        .err_count_o   (err_count_2),
        .state_o       (dbg_state_2)
    );

endmodule
